// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle for mux_rr_arbiter: packed per-channel inputs with
// valid/ready, and a registered output word with out_valid/out_ready.
interface mux_rr_arbiter_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int IDXW = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] data;
    logic [CHANNELS-1:0]       valid;
    logic [CHANNELS-1:0]       ready;
    logic [WIDTH-1:0]          out;
    logic                      out_valid;
    logic                      out_ready;
    logic [IDXW-1:0]           grant;

    // Producer/consumer side (drives inputs, observes outputs)
    modport master (
        output data, valid, out_ready,
        input  ready, out, out_valid, grant
    );

    // Arbiter side
    modport slave (
        input  data, valid, out_ready,
        output ready, out, out_valid, grant
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin N:1 arbiter/mux feeding a single registered output word.
// Ports: clk, reset (sync, active-high), bus (mux_rr_arbiter_if.slave):
//   data/valid/ready per channel in, out/out_valid/out_ready/grant out.
// Optional MUX_RR_LOCK_EN adds input lock: keeps granting channel ptr
// while it stays valid.
module mux_rr_arbiter #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
`ifdef MUX_RR_LOCK_EN
    input  logic                 lock,
`endif
    mux_rr_arbiter_if.slave      bus
);
    localparam int IDXW = $clog2(CHANNELS);

    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [IDXW-1:0]  grant_q, grant_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;

    logic             free;
    logic             found;
    logic [IDXW-1:0]  win;
    logic [IDXW:0]    sum;
    logic [WIDTH-1:0] win_data;
    logic             xfer;

    // Output register may take a new word when empty or being drained.
    assign free = !out_valid_q || bus.out_ready;

    // Search ptr+1 .. ptr+CHANNELS modulo CHANNELS; first valid wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            sum = {1'b0, ptr_q} + (IDXW+1)'(k);
            if (sum >= (IDXW+1)'(CHANNELS))
                sum = sum - (IDXW+1)'(CHANNELS);
            if (!found && bus.valid[sum[IDXW-1:0]]) begin
                found = 1'b1;
                win   = sum[IDXW-1:0];
            end
        end
`ifdef MUX_RR_LOCK_EN
        // Lock keeps the previous winner as long as it still has data.
        if (lock && bus.valid[ptr_q]) begin
            found = 1'b1;
            win   = ptr_q;
        end
`endif
    end

    always_comb begin
        bus.ready = '0;
        if (free && !reset && found)
            bus.ready[win] = 1'b1;
    end

    assign xfer = |bus.ready;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (win == IDXW'(i))
                win_data = bus.data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_d       = win_data;
            out_valid_d = 1'b1;
            grant_d     = win;
            ptr_d       = win;
        end else if (bus.out_ready) begin
            // Consumed with nothing to refill: word and index stay visible.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            grant_q     <= '0;
            ptr_q       <= IDXW'(CHANNELS - 1);
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.grant     = grant_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (4 channels x 32 bits).
// Expected words/grants are queued per scenario and popped each cycle.
module tb_mux_rr_arbiter;
    logic clk;
    logic reset;
`ifdef MUX_RR_LOCK_EN
    logic lock;
`endif
    int checks;
    int failures;

    // {data[31:0], grant[1:0]}
    logic [33:0] exp_q[$];
    logic [33:0] e;

    mux_rr_arbiter_if #(.WIDTH(32), .CHANNELS(4)) bus ();

    mux_rr_arbiter #(.WIDTH(32), .CHANNELS(4)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef MUX_RR_LOCK_EN
        .lock  (lock),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output logic [33:0] v);
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=0 want=entry");
            v = '0;
        end else begin
            v = exp_q.pop_front();
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        bus.valid     = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready got=%b want=0000", bus.ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 32'h0 ||
            bus.grant !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got=%b/%h/%0d want=0/0/0",
                     bus.out_valid, bus.out, bus.grant);
        end
        reset = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        exp_q.push_back({32'hA0, 2'd0});
        exp_q.push_back({32'hA1, 2'd1});
        exp_q.push_back({32'hA2, 2'd2});
        exp_q.push_back({32'hA3, 2'd3});
        exp_q.push_back({32'hA0, 2'd0});
        bus.valid     = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            e = exp_q[0];
            exp_rdy = 4'b0001 << e[1:0];
            checks++;
            if (bus.ready !== exp_rdy) begin
                failures++;
                $display("FAIL rr_ready[%0d] got=%b want=%b",
                         n, bus.ready, exp_rdy);
            end
            tick();
            pop_exp(e);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== e[33:2] ||
                bus.grant !== e[1:0]) begin
                failures++;
                $display("FAIL rr_out[%0d] got=%b/%h/%0d want=1/%h/%0d",
                         n, bus.out_valid, bus.out, bus.grant,
                         e[33:2], e[1:0]);
            end
        end
    endtask

    task automatic test_single_channel();
        for (int n = 0; n < 5; n++)
            exp_q.push_back({32'hA2, 2'd2});
        bus.valid     = 4'b0100;
        bus.out_ready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (bus.ready !== 4'b0100) begin
                failures++;
                $display("FAIL single_ready[%0d] got=%b want=0100",
                         n, bus.ready);
            end
            tick();
            pop_exp(e);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== e[33:2] ||
                bus.grant !== e[1:0]) begin
                failures++;
                $display("FAIL single_out[%0d] got=%b/%h/%0d want=1/%h/%0d",
                         n, bus.out_valid, bus.out, bus.grant,
                         e[33:2], e[1:0]);
            end
        end
    endtask

    // Held word from test_single_channel: A2 on grant 2.
    task automatic test_backpressure();
        bus.valid     = 4'b1111;
        bus.out_ready = 1'b0;
        #1;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (bus.ready !== 4'b0000) begin
                failures++;
                $display("FAIL hold_ready[%0d] got=%b want=0000",
                         n, bus.ready);
            end
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out !== 32'hA2 ||
                bus.grant !== 2'd2) begin
                failures++;
                $display("FAIL hold_out[%0d] got=%b/%h/%0d want=1/a2/2",
                         n, bus.out_valid, bus.out, bus.grant);
            end
        end
        // A channel toggling valid while blocked must not disturb anything.
        bus.valid = 4'b0001;
        tick();
        bus.valid = 4'b1111;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 4'b1000) begin
            failures++;
            $display("FAIL refill_ready got=%b want=1000", bus.ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== 32'hA3 ||
            bus.grant !== 2'd3) begin
            failures++;
            $display("FAIL refill_out got=%b/%h/%0d want=1/a3/3",
                     bus.out_valid, bus.out, bus.grant);
        end
    endtask

    // ptr is 3 here.
    task automatic test_wrap();
        exp_q.push_back({32'hA0, 2'd0});
        exp_q.push_back({32'hA3, 2'd3});
        bus.valid     = 4'b1001;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            #1;
            e = exp_q[0];
            checks++;
            if (bus.ready !== (4'b0001 << e[1:0])) begin
                failures++;
                $display("FAIL wrap_ready[%0d] got=%b want=%b",
                         n, bus.ready, 4'b0001 << e[1:0]);
            end
            tick();
            pop_exp(e);
            checks++;
            if (bus.out !== e[33:2] || bus.grant !== e[1:0]) begin
                failures++;
                $display("FAIL wrap_out[%0d] got=%h/%0d want=%h/%0d",
                         n, bus.out, bus.grant, e[33:2], e[1:0]);
            end
        end
        // Drain with nothing behind it: out/grant hold, out_valid drops.
        bus.valid = 4'b0000;
        #1;
        checks++;
        if (bus.ready !== 4'b0000) begin
            failures++;
            $display("FAIL idle_ready got=%b want=0000", bus.ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 32'hA3 ||
            bus.grant !== 2'd3) begin
            failures++;
            $display("FAIL drain_out got=%b/%h/%0d want=0/a3/3",
                     bus.out_valid, bus.out, bus.grant);
        end
    endtask

    task automatic test_reset_mid();
        bus.valid     = 4'b0100;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.valid     = 4'b1111;
        reset         = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_ready got=%b want=0000", bus.ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out !== 32'h0 ||
            bus.grant !== 2'd0) begin
            failures++;
            $display("FAIL midrst_state got=%b/%h/%0d want=0/0/0",
                     bus.out_valid, bus.out, bus.grant);
        end
        reset     = 1'b0;
        bus.valid = 4'b0110;
        exp_q.push_back({32'hA1, 2'd1});
        tick();
        pop_exp(e);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out !== e[33:2] ||
            bus.grant !== e[1:0]) begin
            failures++;
            $display("FAIL postrst_out got=%b/%h/%0d want=1/%h/%0d",
                     bus.out_valid, bus.out, bus.grant, e[33:2], e[1:0]);
        end
    endtask

`ifdef MUX_RR_LOCK_EN
    task automatic test_lock();
        bus.out_ready = 1'b1;
        bus.valid     = 4'b0010;
        lock          = 1'b0;
        tick();
        for (int n = 0; n < 4; n++)
            exp_q.push_back({32'hA1, 2'd1});
        exp_q.push_back({32'hA0, 2'd0});
        lock      = 1'b1;
        bus.valid = 4'b0011;
        for (int n = 0; n < 5; n++) begin
            if (n == 4) lock = 1'b0;
            tick();
            pop_exp(e);
            checks++;
            if (bus.out !== e[33:2] || bus.grant !== e[1:0]) begin
                failures++;
                $display("FAIL lock_out[%0d] got=%h/%0d want=%h/%0d",
                         n, bus.out, bus.grant, e[33:2], e[1:0]);
            end
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
`ifdef MUX_RR_LOCK_EN
        lock     = 1'b0;
`endif
        bus.valid     = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            bus.data[i*32 +: 32] = 32'hA0 + i;
        tick();
        test_reset();
        test_round_robin();
        test_single_channel();
        test_backpressure();
        test_wrap();
        test_reset_mid();
`ifdef MUX_RR_LOCK_EN
        test_lock();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data word width in bits (legal 1..64).
REQ-002 The block SHALL have parameter CHANNELS, default 4, number of input channels (legal 2..16); IDXW = clog2(CHANNELS).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port data  input  CHANNELS*WIDTH  packed inputs; channel i at bits [i*WIDTH +: WIDTH].
REQ-006 The block SHALL have port valid  input  CHANNELS  per-channel word-available flag.
REQ-007 The block SHALL have port ready  output  CHANNELS  per-channel accept strobe, combinational, at most one bit high.
REQ-008 The block SHALL have port out  output  WIDTH  registered selected word.
REQ-009 The block SHALL have port out_valid  output  1  out holds an unconsumed word.
REQ-010 The block SHALL have port out_ready  input  1  downstream consumes out when out_valid and out_ready are both high.
REQ-011 The block SHALL have port grant  output  IDXW  source channel index of the word in out.

Function
REQ-012 Transfer on channel i SHALL occur in any cycle where valid[i] and ready[i] are both high; data[i] SHALL be captured into out at that edge.
REQ-013 The register SHALL be free when out_valid=0, or when out_valid=1 and out_ready=1 (consume and refill in the same cycle, full throughput).
REQ-014 ready SHALL be all-zero when the register is not free, when reset=1, or when valid is all-zero.
REQ-015 When free, ready SHALL be one-hot at the first channel with valid high, searching ptr+1, ptr+2, ... modulo CHANNELS (wrap from CHANNELS-1 to 0).
REQ-016 ptr SHALL be an internal IDXW-bit register updated to the granted index on each transfer and held otherwise.
REQ-017 Latency SHALL be 1 cycle: the word captured at edge n is on out with out_valid=1 after edge n.
REQ-018 If out is consumed and no channel transfers, out_valid SHALL go 0 at the next edge; out and grant SHALL hold their last values.
REQ-019 While out_valid=1 and out_ready=0, out, grant, and ptr SHALL be stable.
REQ-020 ready SHALL not depend on out_valid of the same channel's prior word; one channel valid continuously with out_ready=1 SHALL transfer every cycle.
REQ-021 A channel dropping valid without a transfer SHALL have no effect on state.

Reset
REQ-022 With reset=1 at an edge: out=0, out_valid=0, grant=0, ptr=CHANNELS-1 (channel 0 has first priority after reset).
REQ-023 Reset mid-operation SHALL discard any held word, with no transfer in that cycle.
REQ-024 ready SHALL be 0 during reset.

Configuration
REQ-025 Macro MUX_RR_LOCK_EN SHALL, when defined, add port lock  input  1; while lock=1 and valid[ptr]=1 and the register is free, ready SHALL select channel ptr instead of the round-robin winner.
REQ-026 With lock=1 and valid[ptr]=0, arbitration SHALL fall back to REQ-015.
REQ-027 Without MUX_RR_LOCK_EN, port lock SHALL be absent, and behaviour SHALL be pure round-robin per REQ-015.

Verification
REQ-028 Reset, then valid=4'b1111, out_ready=1, channel i data=32'hA0+i -> out sequence A0,A1,A2,A3,A0 on consecutive cycles, grant 0,1,2,3,0.
REQ-029 valid=4'b0100 only, out_ready=1, 5 cycles -> ready=4'b0100 every cycle, 5 transfers, grant=2 throughout.
REQ-030 Word held with out_ready=0 for 3 cycles, all valid high -> ready=0 all 3 cycles, out and grant unchanged; out_ready=1 -> consume and refill at the same edge.
REQ-031 ptr=3, valid=4'b1001 -> channel 0 is granted (wrap); next grant is channel 3.
REQ-032 reset asserted while out_valid=1 -> after the edge, out_valid=0, out=0, grant=0; the first post-reset grant goes to the lowest valid channel.
REQ-033 MUX_RR_LOCK_EN defined, lock=1, valid=4'b0011, last grant=1 -> channel 1 is granted 4 consecutive cycles; lock=0 -> next grant is channel 0.
